// File: rtl/tbec_pkg.sv
// Shared types and the TBEC lane code: 16 data bits plus 16 check bits, where
// check[j] = d[j] ^ d[j-1] ^ d[j-3] (indices mod 16).
package tbec_pkg;

  localparam int TBEC_DATA_W = 16;
  localparam int TBEC_CODE_W = 32;

  typedef enum logic [1:0] {
    TBEC_OK     = 2'b00,
    TBEC_CORR   = 2'b01,
    TBEC_UNCORR = 2'b10,
    TBEC_RSVD   = 2'b11
  } tbec_err_e;

  function automatic logic [TBEC_DATA_W-1:0] tbec_checks(input logic [TBEC_DATA_W-1:0] d);
    return d ^ {d[14:0], d[15]} ^ {d[12:0], d[15:13]};
  endfunction

  // Syndrome produced by a flip of data bit i: three distinct odd-weight bits.
  function automatic logic [TBEC_DATA_W-1:0] tbec_col(input int i);
    return (TBEC_DATA_W'(1) << (i % 16)) | (TBEC_DATA_W'(1) << ((i + 1) % 16)) |
           (TBEC_DATA_W'(1) << ((i + 3) % 16));
  endfunction

  // Reserved code 11 counts as uncorrectable.
  function automatic tbec_err_e worst_err(input tbec_err_e a, input tbec_err_e b);
    if (a[1] || b[1]) return TBEC_UNCORR;
    if (a == TBEC_CORR || b == TBEC_CORR) return TBEC_CORR;
    return TBEC_OK;
  endfunction

endpackage

// File: rtl/tbec_decoder.sv
// TBEC decoder: corrects any single flipped bit; other non-zero syndromes are
// reported uncorrectable and the raw data is passed through.
module tbec_decoder
  import tbec_pkg::*;
(
  input  logic [TBEC_CODE_W-1:0] code,
  output logic [TBEC_DATA_W-1:0] data,
  output tbec_err_e              err
);
  logic [TBEC_DATA_W-1:0] syn;
  logic [TBEC_DATA_W-1:0] flip;

  assign syn = code[TBEC_CODE_W-1:TBEC_DATA_W] ^ tbec_checks(code[TBEC_DATA_W-1:0]);

  always_comb begin
    flip = '0;
    for (int i = 0; i < TBEC_DATA_W; i++) begin
      if (syn == tbec_col(i)) flip = flip | (TBEC_DATA_W'(1) << i);
    end
  end

  always_comb begin
    data = code[TBEC_DATA_W-1:0] ^ flip;
    err  = TBEC_OK;
    if (syn != '0) begin
      // weight-1 syndrome is a flipped check bit: data already intact
      if (flip != '0 || $countones(syn) == 1) err = TBEC_CORR;
      else                                    err = TBEC_UNCORR;
    end
  end
endmodule

// File: rtl/tbec_encoder.sv
// TBEC encoder: codeword = {check bits, data}.
module tbec_encoder
  import tbec_pkg::*;
(
  input  logic [TBEC_DATA_W-1:0] data,
  output logic [TBEC_CODE_W-1:0] code
);
  assign code = {tbec_checks(data), data};
endmodule

// File: rtl/tbec_lane_codec.sv
// One lane's encoder/decoder pair.
module tbec_lane_codec
  import tbec_pkg::*;
(
  input  logic [TBEC_DATA_W-1:0] enc_data,
  output logic [TBEC_CODE_W-1:0] enc_code,
  input  logic [TBEC_CODE_W-1:0] dec_code,
  output logic [TBEC_DATA_W-1:0] dec_data,
  output tbec_err_e              dec_err
);
  tbec_encoder u_enc (.data(enc_data), .code(enc_code));
  tbec_decoder u_dec (.code(dec_code), .data(dec_data), .err(dec_err));
endmodule

// File: rtl/tbec_mem_ctrl.sv
// Multi-lane TBEC-protected memory with registered read path, correct-on-read
// write-back, background scrubber and saturating error statistics.
//
// state  | meaning
// IDLE   | accepting host requests; idle counter runs toward a scrub
// RD_MEM | host read: array word registered
// RD_DEC | host read: decode, register response, update statistics
// WB     | write corrected word back to acc_addr_q
// SC_MEM | scrub: array word registered
// SC_DEC | scrub: decode, update statistics, advance scrub address
module tbec_mem_ctrl
  import tbec_pkg::*;
#(
  parameter int LANES          = 2,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CORRECT_WB     = 1,
  parameter int CNT_W          = 16
) (
  input  logic                     tbec_clk,
  input  logic                     tbec_rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [16*LANES-1:0]      req_wdata,
  input  logic [32*LANES-1:0]      inj_mask,
  output logic                     rsp_valid,
  output logic [16*LANES-1:0]      rsp_data,
  output logic [1:0]               rsp_err,
  output logic [2*LANES-1:0]       rsp_lane_err,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt,
  output logic                     ue_valid,
  output logic [ADDR_W-1:0]        ue_addr,
  output logic                     scrub_busy
);
  localparam int  DW       = TBEC_DATA_W * LANES;
  localparam int  CW       = TBEC_CODE_W * LANES;
  localparam bit  SCRUB_EN = (SCRUB_INTERVAL > 0);
  localparam int  SI_W     = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [SI_W-1:0] SI_TERM = SI_W'((SCRUB_INTERVAL > 0) ? SCRUB_INTERVAL - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD_MEM, RD_DEC, WB, SC_MEM, SC_DEC} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] acc_addr_q, scrub_addr_q;
  logic [SI_W-1:0]   idle_cnt_q;
  logic [CW-1:0]     rd_word_q;
  logic [DW-1:0]     wb_data_q;
  logic              wb_scrub_q;
  logic [CW-1:0]     mem [DEPTH];

  logic [DW-1:0]        enc_in, dec_data;
  logic [CW-1:0]        enc_code;
  logic [2*LANES-1:0]   lane_err_flat;
  tbec_err_e            lane_err [LANES];
  tbec_err_e            worst_chain [LANES+1];
  tbec_err_e            worst;
  logic                 xfer, scrub_go, dec_state;

  assign req_ready  = (state_q == IDLE);
  assign xfer       = req_valid & req_ready;
  assign scrub_go   = SCRUB_EN && (state_q == IDLE) && (idle_cnt_q == SI_TERM) && !req_valid;
  assign dec_state  = (state_q == RD_DEC) || (state_q == SC_DEC);
  assign scrub_busy = (state_q == SC_MEM) || (state_q == SC_DEC) || (state_q == WB && wb_scrub_q);
  assign enc_in     = (state_q == WB) ? wb_data_q : req_wdata;

  assign worst_chain[0] = TBEC_OK;
  assign worst          = worst_chain[LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tbec_lane_codec u_codec (
      .enc_data (enc_in[TBEC_DATA_W*g +: TBEC_DATA_W]),
      .enc_code (enc_code[TBEC_CODE_W*g +: TBEC_CODE_W]),
      .dec_code (rd_word_q[TBEC_CODE_W*g +: TBEC_CODE_W]),
      .dec_data (dec_data[TBEC_DATA_W*g +: TBEC_DATA_W]),
      .dec_err  (lane_err[g])
    );
    assign lane_err_flat[2*g +: 2] = lane_err[g];
    assign worst_chain[g+1]        = worst_err(worst_chain[g], lane_err[g]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer && !req_we) state_d = RD_MEM;
        else if (scrub_go)   state_d = SC_MEM;
      end
      RD_MEM: state_d = RD_DEC;
      SC_MEM: state_d = SC_DEC;
      RD_DEC, SC_DEC: begin
        if (CORRECT_WB != 0 && worst == TBEC_CORR) state_d = WB;
        else                                       state_d = IDLE;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array has no reset; contents survive tbec_rst_n.
  always_ff @(posedge tbec_clk) begin
    if (xfer && req_we)     mem[req_addr]   <= enc_code ^ inj_mask;
    else if (state_q == WB) mem[acc_addr_q] <= enc_code;
    if (state_q == RD_MEM || state_q == SC_MEM) rd_word_q <= mem[acc_addr_q];
  end

  always_ff @(posedge tbec_clk or negedge tbec_rst_n) begin
    if (!tbec_rst_n) begin
      state_q      <= IDLE;
      acc_addr_q   <= '0;
      scrub_addr_q <= '0;
      idle_cnt_q   <= '0;
      wb_data_q    <= '0;
      wb_scrub_q   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 2'b00;
      rsp_lane_err <= '0;
      corr_cnt     <= '0;
      uncorr_cnt   <= '0;
      ue_valid     <= 1'b0;
      ue_addr      <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      if (xfer)          acc_addr_q <= req_addr;
      else if (scrub_go) acc_addr_q <= scrub_addr_q;
      // A host request at the terminal count holds it, so the scrub follows
      // on the next idle cycle.
      if (SCRUB_EN && state_q == IDLE) begin
        if (idle_cnt_q == SI_TERM) begin
          if (!req_valid) idle_cnt_q <= '0;
        end else if (xfer) idle_cnt_q <= '0;
        else               idle_cnt_q <= idle_cnt_q + SI_W'(1);
      end
      if (dec_state) begin
        wb_data_q  <= dec_data;
        wb_scrub_q <= (state_q == SC_DEC);
      end
      if (state_q == RD_DEC) begin
        rsp_valid    <= 1'b1;
        rsp_data     <= dec_data;
        rsp_err      <= worst;
        rsp_lane_err <= lane_err_flat;
      end
      if (state_q == SC_DEC)
        scrub_addr_q <= (scrub_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : scrub_addr_q + ADDR_W'(1);
      if (dec_state && worst == TBEC_UNCORR) ue_addr <= acc_addr_q;
      if (clr_cnt) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
        ue_valid   <= 1'b0;
      end else if (dec_state) begin
        if (worst == TBEC_UNCORR) begin
          ue_valid <= 1'b1;
          if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end else if (worst == TBEC_CORR) begin
          if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule
